lp805x_sfr_cdc_link: RTL and testbench
======================================

Name: lp805x_sfr_cdc_link

Overview:
- Clock-domain-crossing link between the CPU SFR bus (clk_cpu domain) and a peripheral running on clk.
- Downstream path: carries the packed 29-bit SFR request word to clk through a single-entry toggle-handshake channel, then decodes it into strobes, addresses and data.
- Upstream path: registers the peripheral's 9-bit read response on clk and carries it back to clk_cpu through a second, identical channel.

Parameters:
- SYNC_STAGES, 2, flops in each toggle synchronizer (minimum 2).
- DN_WIDTH, 29, width of the downstream request word.
- UP_WIDTH, 9, width of the upstream response word.

Ports:
- clk  in  1  peripheral clock; read side of downstream channel, write side of upstream channel.
- rst  in  1  asynchronous, active-high reset applied to both domains.
- clk_cpu  in  1  CPU clock.
- sfr_bus  in  29  packed request: [28]wr [27]rd [26]wr_bit [25]rd_bit [24:17]wr_addr [16:9]rd_addr [8:1]data_in [0]bit_in.
- sfr_put  in  1  clk_cpu; push request word.
- sfr_wrdy  out  1  clk_cpu; downstream channel can accept.
- dn_get  in  1  clk; consume current request.
- dn_rrdy  out  1  clk; request available.
- wr, rd, wr_bit, rd_bit  out  1 each  clk; decoded strobes, gated by dn_rrdy.
- wr_addr, rd_addr  out  8 each  clk; decoded addresses.
- data_in  out  8  clk; decoded write data.
- bit_in  out  1  clk; decoded write bit.
- data_read  in  8  clk; peripheral read byte.
- bit_read  in  1  clk; peripheral read bit.
- up_load  in  1  clk; capture {data_read, bit_read}.
- up_put  in  1  clk; push response.
- up_wrdy  out  1  clk; upstream channel can accept.
- sfr_get  in  1  clk_cpu; consume response.
- sfr_rrdy  out  1  clk_cpu; response available.
- sfr_data_out  out  8  clk_cpu; response [8:1].
- sfr_bit_out  out  1  clk_cpu; response [0].

Behaviour:
- Channel write side, on wput while wrdy=1:
  - capture data into the write holding register;
  - flip wtog;
  - wrdy falls on the next edge.
  - wput while wrdy=0 is ignored; data and toggle are unchanged.
- The write holding register is stable while wrdy=0, so the multi-bit data needs no synchronizer.
- Channel read side:
  - wtog passes through SYNC_STAGES flops into the read clock.
  - rrdy = (synced wtog != rtog).
  - rrdy rises no later than SYNC_STAGES+1 read-clock edges after the capturing write edge.
  - Read data is the write holding register, valid whenever rrdy=1.
- Consume:
  - rget while rrdy=1 flips rtog, so rrdy falls the next edge.
  - rtog is synchronized back to the write clock; wrdy=1 when the synced rtog equals wtog, within SYNC_STAGES+1 write-clock edges.
  - rget while rrdy=0 is ignored.
- Throughput: one word in flight per channel, so no overflow is possible.
- Decode:
  - Fields are pure slices of the downstream read data.
  - The four strobes are ANDed with dn_rrdy.
  - Addresses and data are ungated.
- Response register:
  - On clk, up_load=1 captures {data_read, bit_read}; otherwise it holds.
  - The upstream channel captures the register's current value on up_put, so up_load must precede up_put by at least one clk.
  - Simultaneous up_load and up_put sends the old value.
- Reset values:
  - all toggles and synchronizer flops 0;
  - holding and response registers 0;
  - sfr_wrdy = up_wrdy = 1;
  - dn_rrdy = sfr_rrdy = 0;
  - all decoded outputs and sfr_data_out/sfr_bit_out 0.
- Reset mid-transfer discards the in-flight word in both directions.
- Put and get in the same cycles on opposite sides are legal; ordering is governed only by the toggles.

Optional Feature:
- Macro LP805X_SFR_SYNC_BYPASS_EN, for use when clk and clk_cpu are the same clock.
- Defined:
  - synchronizer flops are removed and the toggles are compared directly;
  - rrdy rises one edge after put;
  - wrdy returns one edge after get.
- Undefined: full SYNC_STAGES synchronization as described above.
- Port list is identical in both builds.

Decomposition:
- Shared package lp805x_sfr_cdc_pkg: bit positions and widths of the 29-bit request fields and the 9-bit response fields, plus the default SYNC_STAGES.
- One sub-module, lp805x_sync_channel: parameterised width, ports wclk/rclk/rst/wput/wrdy/wdata/rget/rrdy/rdata; instantiated twice.
- Decode and response register live in the top level.

Test Plan:
- Reset: assert rst mid-operation -> sfr_wrdy=1, up_wrdy=1, dn_rrdy=0, sfr_rrdy=0, all decoded outputs 0.
- Byte write: sfr_bus = wr=1, wr_addr=0x8C, data_in=0xA5, put -> dn_rrdy within 3 clk; wr=1, wr_addr=0x8C, data_in=0xA5. After dn_get: wr=0, sfr_wrdy=1 within 3 clk_cpu.
- Bit write: wr=1, wr_bit=1, wr_addr=0x8B, bit_in=1 -> decoded wr_bit=1, wr_addr[7:3]=0x11, wr_addr[2:0]=3, bit_in=1.
- Back-pressure: second sfr_put while sfr_wrdy=0 with different data -> ignored; first word delivered unchanged; no second dn_rrdy.
- Read return: data_read=0x3C, bit_read=1, up_load, then up_put -> sfr_rrdy within 3 clk_cpu; sfr_data_out=0x3C, sfr_bit_out=1. sfr_get -> up_wrdy=1.
- Clock ratios clk:clk_cpu of 1:3 and 3:1 with 100 random transfers -> every word delivered exactly once, in order, uncorrupted.

Source files
------------

// File: rtl/lp805x_sfr_cdc_pkg.sv
// ---------------------------------------------------------------------------
// lp805x_sfr_cdc_pkg
//
// Shared definitions for the SFR clock-domain-crossing link.
//   - Field positions/widths of the 29-bit downstream request word
//   - Field positions/widths of the 9-bit upstream response word
//   - Packed struct views of both words (pure bit slices, no logic)
//   - Default synchronizer depth
//
// Optional build macro used by the users of this package:
//   LP805X_SFR_SYNC_BYPASS_EN  - both clocks are the same clock; the toggle
//                                synchronizers are removed.
// ---------------------------------------------------------------------------
package lp805x_sfr_cdc_pkg;

    // Synchronizer depth; two flops is the minimum for metastability settling.
    localparam int SYNC_STAGES_DEFAULT = 2;

    localparam int SFR_ADDR_W = 8;
    localparam int SFR_DATA_W = 8;

    // Downstream request word layout.
    localparam int DN_WORD_W      = 29;
    localparam int DN_WR_POS      = 28;
    localparam int DN_RD_POS      = 27;
    localparam int DN_WR_BIT_POS  = 26;
    localparam int DN_RD_BIT_POS  = 25;
    localparam int DN_WR_ADDR_LSB = 17;
    localparam int DN_RD_ADDR_LSB = 9;
    localparam int DN_DATA_LSB    = 1;
    localparam int DN_BIT_IN_POS  = 0;

    // Upstream response word layout.
    localparam int UP_WORD_W    = 9;
    localparam int UP_DATA_LSB  = 1;
    localparam int UP_BIT_POS   = 0;

    // Field order matches the positions above, MSB first.
    typedef struct packed {
        logic                  wr;
        logic                  rd;
        logic                  wr_bit;
        logic                  rd_bit;
        logic [SFR_ADDR_W-1:0] wr_addr;
        logic [SFR_ADDR_W-1:0] rd_addr;
        logic [SFR_DATA_W-1:0] data_in;
        logic                  bit_in;
    } sfr_req_t;

    typedef struct packed {
        logic [SFR_DATA_W-1:0] data;
        logic                  bit_val;
    } sfr_rsp_t;

endpackage : lp805x_sfr_cdc_pkg

// File: rtl/lp805x_sync_channel.sv
// ---------------------------------------------------------------------------
// lp805x_sync_channel
//
// Single-entry toggle-handshake channel between a write clock and a read
// clock. A word is captured into a holding register and announced by
// flipping wtog; the reader acknowledges by flipping rtog. Because the
// holding register only changes while the channel is empty (wrdy=1), the
// multi-bit payload itself needs no synchronizer - only the two toggles
// cross.
//
// Parameters:
//   WIDTH        payload width
//   SYNC_STAGES  flops per toggle synchronizer (>= 2)
//
// Ports:
//   wclk   in   write-side clock
//   rclk   in   read-side clock
//   rst    in   asynchronous active-high reset, both sides
//   wput   in   wclk: push wdata (ignored while wrdy=0)
//   wrdy   out  wclk: channel empty, may push
//   wdata  in   wclk: payload
//   rget   in   rclk: consume current word (ignored while rrdy=0)
//   rrdy   out  rclk: word available
//   rdata  out  rclk: payload, valid while rrdy=1
//
// Build macro LP805X_SFR_SYNC_BYPASS_EN: wclk and rclk are the same clock,
// the toggles are compared directly without synchronizer flops.
// ---------------------------------------------------------------------------
module lp805x_sync_channel #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wclk,
    input  logic             rclk,
    input  logic             rst,
    input  logic             wput,
    output logic             wrdy,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rget,
    output logic             rrdy,
    output logic [WIDTH-1:0] rdata
);

    logic             wtog_reg;
    logic             rtog_reg;
    logic [WIDTH-1:0] whold_reg;

    // Toggle values as observed in the opposite domain.
    logic             wtog_seen;
    logic             rtog_seen;

    // Write side: capture and announce.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wtog_reg  <= 1'b0;
            whold_reg <= '0;
        end else if (wput && wrdy) begin
            wtog_reg  <= ~wtog_reg;
            whold_reg <= wdata;
        end
    end

    // Read side: acknowledge.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rtog_reg <= 1'b0;
        end else if (rget && rrdy) begin
            rtog_reg <= ~rtog_reg;
        end
    end

`ifdef LP805X_SFR_SYNC_BYPASS_EN
    // Same clock on both sides: the toggles are already synchronous.
    assign wtog_seen = wtog_reg;
    assign rtog_seen = rtog_reg;
`else
    logic [SYNC_STAGES-1:0] wtog_sync_reg;  // in rclk domain
    logic [SYNC_STAGES-1:0] rtog_sync_reg;  // in wclk domain

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            wtog_sync_reg <= '0;
        end else begin
            wtog_sync_reg <= {wtog_sync_reg[SYNC_STAGES-2:0], wtog_reg};
        end
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            rtog_sync_reg <= '0;
        end else begin
            rtog_sync_reg <= {rtog_sync_reg[SYNC_STAGES-2:0], rtog_reg};
        end
    end

    assign wtog_seen = wtog_sync_reg[SYNC_STAGES-1];
    assign rtog_seen = rtog_sync_reg[SYNC_STAGES-1];
`endif

    // Toggles differ -> a word is outstanding.
    assign rrdy  = wtog_seen ^ rtog_reg;
    assign wrdy  = ~(rtog_seen ^ wtog_reg);
    assign rdata = whold_reg;

endmodule : lp805x_sync_channel

// File: rtl/lp805x_sfr_cdc_link.sv
// ---------------------------------------------------------------------------
// lp805x_sfr_cdc_link
//
// Links the CPU SFR bus (clk_cpu) with a peripheral on clk.
//   Downstream: 29-bit request word -> toggle channel -> decoded strobes,
//               addresses and data on clk. Strobes are qualified by dn_rrdy;
//               addresses/data are raw slices of the held word.
//   Upstream:   {data_read, bit_read} captured into a response register on
//               up_load, pushed on up_put through a second channel, and
//               presented as sfr_data_out/sfr_bit_out on clk_cpu.
//
// Ports:
//   clk, clk_cpu            peripheral / CPU clocks
//   rst                     asynchronous active-high reset, both domains
//   sfr_bus[28:0], sfr_put  clk_cpu: request word and push
//   sfr_wrdy                clk_cpu: downstream channel can accept
//   dn_get / dn_rrdy        clk: consume / request available
//   wr, rd, wr_bit, rd_bit  clk: decoded strobes (gated by dn_rrdy)
//   wr_addr, rd_addr        clk: decoded addresses
//   data_in, bit_in         clk: decoded write data / bit
//   data_read, bit_read     clk: peripheral read response
//   up_load                 clk: capture response into response register
//   up_put / up_wrdy        clk: push response / upstream can accept
//   sfr_get / sfr_rrdy      clk_cpu: consume / response available
//   sfr_data_out, sfr_bit_out  clk_cpu: response fields
//
// Build macro LP805X_SFR_SYNC_BYPASS_EN: clk and clk_cpu are the same clock;
// both channels compare toggles directly. Port list is unchanged.
// ---------------------------------------------------------------------------
module lp805x_sfr_cdc_link
    import lp805x_sfr_cdc_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int DN_WIDTH    = DN_WORD_W,
    parameter int UP_WIDTH    = UP_WORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_cpu,
    input  logic [DN_WIDTH-1:0]   sfr_bus,
    input  logic                  sfr_put,
    output logic                  sfr_wrdy,
    input  logic                  dn_get,
    output logic                  dn_rrdy,
    output logic                  wr,
    output logic                  rd,
    output logic                  wr_bit,
    output logic                  rd_bit,
    output logic [SFR_ADDR_W-1:0] wr_addr,
    output logic [SFR_ADDR_W-1:0] rd_addr,
    output logic [SFR_DATA_W-1:0] data_in,
    output logic                  bit_in,
    input  logic [SFR_DATA_W-1:0] data_read,
    input  logic                  bit_read,
    input  logic                  up_load,
    input  logic                  up_put,
    output logic                  up_wrdy,
    input  logic                  sfr_get,
    output logic                  sfr_rrdy,
    output logic [SFR_DATA_W-1:0] sfr_data_out,
    output logic                  sfr_bit_out
);

    // -----------------------------------------------------------------------
    // Downstream: CPU -> peripheral
    // -----------------------------------------------------------------------
    logic [DN_WIDTH-1:0] dn_rdata;
    sfr_req_t            dn_req;

    lp805x_sync_channel #(
        .WIDTH       (DN_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dn_channel (
        .wclk  (clk_cpu),
        .rclk  (clk),
        .rst   (rst),
        .wput  (sfr_put),
        .wrdy  (sfr_wrdy),
        .wdata (sfr_bus),
        .rget  (dn_get),
        .rrdy  (dn_rrdy),
        .rdata (dn_rdata)
    );

    assign dn_req = dn_rdata;

    // Strobes must never fire from a stale (already consumed) word, so they
    // are qualified by dn_rrdy; index 3..0 = wr, rd, wr_bit, rd_bit.
    logic [3:0] strobe_raw;
    logic [3:0] strobe_gated;

    assign strobe_raw = {dn_req.wr, dn_req.rd, dn_req.wr_bit, dn_req.rd_bit};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_strobe
            assign strobe_gated[gi] = strobe_raw[gi] & dn_rrdy;
        end
    endgenerate

    assign wr      = strobe_gated[3];
    assign rd      = strobe_gated[2];
    assign wr_bit  = strobe_gated[1];
    assign rd_bit  = strobe_gated[0];
    assign wr_addr = dn_req.wr_addr;
    assign rd_addr = dn_req.rd_addr;
    assign data_in = dn_req.data_in;
    assign bit_in  = dn_req.bit_in;

    // -----------------------------------------------------------------------
    // Upstream: peripheral -> CPU
    // -----------------------------------------------------------------------
    // The channel samples this register, not data_read directly, so a load
    // and a put in the same cycle sends the previously loaded value.
    logic [UP_WIDTH-1:0] resp_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_reg <= '0;
        end else if (up_load) begin
            resp_reg <= {data_read, bit_read};
        end
    end

    logic [UP_WIDTH-1:0] up_rdata;
    sfr_rsp_t            up_rsp;

    lp805x_sync_channel #(
        .WIDTH       (UP_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_up_channel (
        .wclk  (clk),
        .rclk  (clk_cpu),
        .rst   (rst),
        .wput  (up_put),
        .wrdy  (up_wrdy),
        .wdata (resp_reg),
        .rget  (sfr_get),
        .rrdy  (sfr_rrdy),
        .rdata (up_rdata)
    );

    assign up_rsp       = up_rdata;
    assign sfr_data_out = up_rsp.data;
    assign sfr_bit_out  = up_rsp.bit_val;

endmodule : lp805x_sfr_cdc_link

// File: tb/tb_lp805x_sfr_cdc_link.sv
// ---------------------------------------------------------------------------
// tb_lp805x_sfr_cdc_link
//
// Directed cases with literal expectations, then randomized traffic in both
// directions at two clock ratios. A queue per direction holds the words the
// sender successfully handed over; receivers compare every ready cycle
// against the queue head and pop on consume.
// ---------------------------------------------------------------------------
module tb_lp805x_sfr_cdc_link;

    logic        clk = 1'b0;
    logic        clk_cpu = 1'b0;
    logic        rst = 1'b1;
    logic [28:0] sfr_bus = '0;
    logic        sfr_put = 1'b0;
    logic        sfr_wrdy;
    logic        dn_get = 1'b0;
    logic        dn_rrdy;
    logic        wr, rd, wr_bit, rd_bit;
    logic [7:0]  wr_addr, rd_addr, data_in;
    logic        bit_in;
    logic [7:0]  data_read = '0;
    logic        bit_read = 1'b0;
    logic        up_load = 1'b0;
    logic        up_put = 1'b0;
    logic        up_wrdy;
    logic        sfr_get = 1'b0;
    logic        sfr_rrdy;
    logic [7:0]  sfr_data_out;
    logic        sfr_bit_out;

    int clk_half = 5;
    int cpu_half = 7;

    initial forever #(clk_half) clk = ~clk;
    initial forever #(cpu_half) clk_cpu = ~clk_cpu;

    lp805x_sfr_cdc_link dut (
        .clk          (clk),
        .rst          (rst),
        .clk_cpu      (clk_cpu),
        .sfr_bus      (sfr_bus),
        .sfr_put      (sfr_put),
        .sfr_wrdy     (sfr_wrdy),
        .dn_get       (dn_get),
        .dn_rrdy      (dn_rrdy),
        .wr           (wr),
        .rd           (rd),
        .wr_bit       (wr_bit),
        .rd_bit       (rd_bit),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .data_in      (data_in),
        .bit_in       (bit_in),
        .data_read    (data_read),
        .bit_read     (bit_read),
        .up_load      (up_load),
        .up_put       (up_put),
        .up_wrdy      (up_wrdy),
        .sfr_get      (sfr_get),
        .sfr_rrdy     (sfr_rrdy),
        .sfr_data_out (sfr_data_out),
        .sfr_bit_out  (sfr_bit_out)
    );

    logic [28:0] dn_obs;
    logic [8:0]  up_obs;
    assign dn_obs = {wr, rd, wr_bit, rd_bit, wr_addr, rd_addr, data_in, bit_in};
    assign up_obs = {sfr_data_out, sfr_bit_out};

    int checks = 0;
    int errors = 0;

    logic [28:0] dn_q[$];
    logic [8:0]  up_q[$];
    logic [8:0]  resp_model = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Build a request word from its fields (field order from the bus map).
    function automatic logic [28:0] mk_req(input logic w, input logic r, input logic wb,
                                           input logic rb, input logic [7:0] wa,
                                           input logic [7:0] ra, input logic [7:0] d,
                                           input logic b);
        return {w, r, wb, rb, wa, ra, d, b};
    endfunction

    // ---------------- directed helpers ----------------
    task automatic cpu_put(input logic [28:0] w);
        @(negedge clk_cpu);
        sfr_bus = w;
        sfr_put = 1'b1;
        @(posedge clk_cpu);
        #1 sfr_put = 1'b0;
    endtask

    task automatic periph_get();
        @(negedge clk);
        dn_get = 1'b1;
        @(posedge clk);
        #1 dn_get = 1'b0;
    endtask

    task automatic periph_put(input logic ld, input logic pt, input logic [7:0] d, input logic b);
        @(negedge clk);
        data_read = d;
        bit_read  = b;
        up_load   = ld;
        up_put    = pt;
        @(posedge clk);
        #1;
        up_load = 1'b0;
        up_put  = 1'b0;
    endtask

    task automatic cpu_get();
        @(negedge clk_cpu);
        sfr_get = 1'b1;
        @(posedge clk_cpu);
        #1 sfr_get = 1'b0;
    endtask

    task automatic wait_dn_rrdy(input string nm);
        int n = 0;
        while (!dn_rrdy && n < 3) begin @(posedge clk); #1; n++; end
        check(nm, 32'(dn_rrdy), 32'd1);
    endtask

    task automatic wait_sfr_wrdy(input string nm);
        int n = 0;
        while (!sfr_wrdy && n < 3) begin @(posedge clk_cpu); #1; n++; end
        check(nm, 32'(sfr_wrdy), 32'd1);
    endtask

    task automatic wait_sfr_rrdy(input string nm);
        int n = 0;
        while (!sfr_rrdy && n < 3) begin @(posedge clk_cpu); #1; n++; end
        check(nm, 32'(sfr_rrdy), 32'd1);
    endtask

    task automatic wait_up_wrdy(input string nm);
        int n = 0;
        while (!up_wrdy && n < 3) begin @(posedge clk); #1; n++; end
        check(nm, 32'(up_wrdy), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sfr_wrdy"}, 32'(sfr_wrdy), 32'd1);
        check({tag, "_up_wrdy"},  32'(up_wrdy),  32'd1);
        check({tag, "_dn_rrdy"},  32'(dn_rrdy),  32'd0);
        check({tag, "_sfr_rrdy"}, 32'(sfr_rrdy), 32'd0);
        check({tag, "_decoded"},  32'(dn_obs),   32'd0);
        check({tag, "_sfr_out"},  32'(up_obs),   32'd0);
    endtask

    // Count ready pulses over an idle window; any pulse is a duplicate.
    task automatic idle_no_ready(input string nm, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (dn_rrdy || sfr_rrdy) seen++;
        end
        check(nm, 32'(seen), 32'd0);
    endtask

    // ---------------- random traffic processes ----------------
    localparam int LIMIT = 20000;

    task automatic cpu_producer(input int n);
        int sent = 0;
        int cyc = 0;
        while (sent < n && cyc < LIMIT) begin
            @(negedge clk_cpu);
            cyc++;
            sfr_bus = 29'($urandom);
            sfr_put = 1'($urandom_range(0, 1));
            if (sfr_put && sfr_wrdy) begin
                dn_q.push_back(sfr_bus);
                sent++;
            end
        end
        @(negedge clk_cpu);
        sfr_put = 1'b0;
        check("dn_sent_all", 32'(sent), 32'(n));
    endtask

    task automatic periph_consumer(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (dn_rrdy) begin
                if (dn_q.size() == 0) check("dn_spurious", 32'd1, 32'd0);
                else                  check("dn_word", 32'(dn_obs), 32'(dn_q[0]));
            end else begin
                check("dn_strobe_gate", 32'({wr, rd, wr_bit, rd_bit}), 32'd0);
            end
            dn_get = 1'($urandom_range(0, 1));
            if (dn_get && dn_rrdy && dn_q.size() != 0) begin
                void'(dn_q.pop_front());
                got++;
            end
        end
        @(negedge clk);
        dn_get = 1'b0;
        check("dn_got_all", 32'(got), 32'(n));
    endtask

    task automatic periph_producer(input int n);
        int sent = 0;
        int cyc = 0;
        while (sent < n && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            data_read = 8'($urandom);
            bit_read  = 1'($urandom);
            up_load   = ($urandom_range(0, 3) == 0);
            up_put    = 1'($urandom_range(0, 1));
            // The channel takes the register's value from before this load.
            if (up_put && up_wrdy) begin
                up_q.push_back(resp_model);
                sent++;
            end
            if (up_load) resp_model = {data_read, bit_read};
        end
        @(negedge clk);
        up_put  = 1'b0;
        up_load = 1'b0;
        check("up_sent_all", 32'(sent), 32'(n));
    endtask

    task automatic cpu_consumer(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < LIMIT) begin
            @(negedge clk_cpu);
            cyc++;
            if (sfr_rrdy) begin
                if (up_q.size() == 0) check("up_spurious", 32'd1, 32'd0);
                else                  check("up_word", 32'(up_obs), 32'(up_q[0]));
            end
            sfr_get = 1'($urandom_range(0, 1));
            if (sfr_get && sfr_rrdy && up_q.size() != 0) begin
                void'(up_q.pop_front());
                got++;
            end
        end
        @(negedge clk_cpu);
        sfr_get = 1'b0;
        check("up_got_all", 32'(got), 32'(n));
    endtask

    task automatic run_random(input int n);
        fork
            cpu_producer(n);
            periph_consumer(n);
            periph_producer(n);
            cpu_consumer(n);
        join
        idle_no_ready("rand_no_extra", 20);
        check("rand_dn_q_empty", 32'(dn_q.size()), 32'd0);
        check("rand_up_q_empty", 32'(up_q.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [28:0] w_a;
    logic [28:0] w_b;

    initial begin
        // Power-on reset.
        repeat (3) @(posedge clk_cpu);
        #1 check_reset_state("por");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk_cpu);

        // Byte write to 0x8C with 0xA5.
        w_a = mk_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h8C, 8'h00, 8'hA5, 1'b0);
        cpu_put(w_a);
        check("byte_wrdy_low", 32'(sfr_wrdy), 32'd0);
        wait_dn_rrdy("byte_rrdy");
        check("byte_wr", 32'(wr), 32'd1);
        check("byte_rd", 32'(rd), 32'd0);
        check("byte_wr_addr", 32'(wr_addr), 32'h8C);
        check("byte_data_in", 32'(data_in), 32'hA5);
        periph_get();
        check("byte_rrdy_clear", 32'(dn_rrdy), 32'd0);
        check("byte_wr_clear", 32'(wr), 32'd0);
        wait_sfr_wrdy("byte_wrdy_back");

        // Bit write: bit address 0x8B = byte 0x11, bit 3.
        w_a = mk_req(1'b1, 1'b0, 1'b1, 1'b0, 8'h8B, 8'h00, 8'h00, 1'b1);
        cpu_put(w_a);
        wait_dn_rrdy("bit_rrdy");
        check("bit_wr_bit", 32'(wr_bit), 32'd1);
        check("bit_addr_hi", 32'(wr_addr[7:3]), 32'h11);
        check("bit_addr_lo", 32'(wr_addr[2:0]), 32'd3);
        check("bit_bit_in", 32'(bit_in), 32'd1);
        periph_get();
        wait_sfr_wrdy("bit_wrdy_back");

        // Back-pressure: second put while busy must be dropped.
        w_a = mk_req(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h81, 8'h00, 1'b0);
        w_b = mk_req(1'b1, 1'b0, 1'b0, 1'b1, 8'hF0, 8'h0F, 8'h5A, 1'b1);
        cpu_put(w_a);
        check("bp_wrdy_low", 32'(sfr_wrdy), 32'd0);
        cpu_put(w_b);
        wait_dn_rrdy("bp_rrdy");
        check("bp_word", 32'(dn_obs), 32'(w_a));
        periph_get();
        wait_sfr_wrdy("bp_wrdy_back");
        idle_no_ready("bp_no_second", 12);

        // Read return.
        periph_put(1'b1, 1'b0, 8'h3C, 1'b1);
        periph_put(1'b0, 1'b1, 8'h00, 1'b0);
        check("rd_up_wrdy_low", 32'(up_wrdy), 32'd0);
        wait_sfr_rrdy("rd_rrdy");
        check("rd_data", 32'(sfr_data_out), 32'h3C);
        check("rd_bit", 32'(sfr_bit_out), 32'd1);
        cpu_get();
        check("rd_rrdy_clear", 32'(sfr_rrdy), 32'd0);
        wait_up_wrdy("rd_up_wrdy_back");

        // Load and put together: the previously loaded value goes out.
        periph_put(1'b1, 1'b1, 8'h55, 1'b0);
        wait_sfr_rrdy("simul_rrdy");
        check("simul_old_value", 32'(up_obs), 32'({8'h3C, 1'b1}));
        cpu_get();
        wait_up_wrdy("simul_up_wrdy_back");
        periph_put(1'b0, 1'b1, 8'h00, 1'b0);
        wait_sfr_rrdy("next_rrdy");
        check("next_new_value", 32'(up_obs), 32'({8'h55, 1'b0}));
        cpu_get();
        wait_up_wrdy("next_up_wrdy_back");

        // Reset with words in flight in both directions.
        w_a = mk_req(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        periph_put(1'b1, 1'b0, 8'hC3, 1'b1);
        fork
            cpu_put(w_a);
            periph_put(1'b0, 1'b1, 8'h00, 1'b0);
        join
        #3 rst = 1'b1;
        #1 check_reset_state("mid_rst");
        repeat (3) @(posedge clk_cpu);
        @(negedge clk);
        rst = 1'b0;
        resp_model = '0;
        idle_no_ready("rst_discard", 15);

        // Random traffic: clk three times faster than clk_cpu, then reverse.
        clk_half = 5;
        cpu_half = 15;
        repeat (4) @(posedge clk_cpu);
        run_random(100);

        clk_half = 15;
        cpu_half = 5;
        repeat (4) @(posedge clk);
        run_random(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_lp805x_sfr_cdc_link
